// File: rtl/serdes_tx_link_sequencer.sv
// Transmit link sequencer in front of the 8b/10b encoder: comma alignment burst at link-up,
// then upstream bytes or idle commas, with periodic K28.0 clock-compensation skip sets.
module serdes_tx_link_sequencer #(
    parameter int ALIGN_CNT     = 16,
    parameter int SKIP_INTERVAL = 1024,
    parameter int SKIP_LEN      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       link_en,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] enc_data,
    output logic       enc_k,
    output logic       enc_valid,
    output logic       link_up
);

    localparam int AW = (ALIGN_CNT > 1) ? $clog2(ALIGN_CNT) : 1;
    localparam int SW = $clog2(SKIP_INTERVAL);
    localparam int KW = (SKIP_LEN > 1) ? $clog2(SKIP_LEN) : 1;

    localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_CNT - 1);
    localparam logic [SW-1:0] SYM_LAST   = SW'(SKIP_INTERVAL - 1);
    localparam logic [KW-1:0] SKIP_LAST  = KW'(SKIP_LEN - 1);

    localparam logic [7:0] COMMA    = 8'hBC;
    localparam logic [7:0] SKIP_SYM = 8'h1C;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_ALIGN,
        ST_RUN,
        ST_SKIP
    } state_t;

    state_t          state;
    logic [AW-1:0]   align_cnt;
    logic [SW-1:0]   sym_cnt;
    logic [KW-1:0]   skip_cnt;

    assign s_ready = link_en && (state == ST_RUN);

    // Each cycle issues at most one symbol; it lands on the registered enc_* outputs at the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_OFF;
            align_cnt <= '0;
            sym_cnt   <= '0;
            skip_cnt  <= '0;
            enc_data  <= 8'h00;
            enc_k     <= 1'b0;
            enc_valid <= 1'b0;
            link_up   <= 1'b0;
        end else if (!link_en) begin
            state     <= ST_OFF;
            align_cnt <= '0;
            sym_cnt   <= '0;
            skip_cnt  <= '0;
            enc_data  <= 8'h00;
            enc_k     <= 1'b0;
            enc_valid <= 1'b0;
            link_up   <= 1'b0;
        end else begin
            case (state)
                ST_OFF: begin
                    state     <= ST_ALIGN;
                    enc_data  <= 8'h00;
                    enc_k     <= 1'b0;
                    enc_valid <= 1'b0;
                    link_up   <= 1'b0;
                end
                ST_ALIGN: begin
                    enc_data  <= COMMA;
                    enc_k     <= 1'b1;
                    enc_valid <= 1'b1;
                    if (align_cnt == ALIGN_LAST) begin
                        align_cnt <= '0;
                        state     <= ST_RUN;
                        link_up   <= 1'b1;
                    end else begin
                        align_cnt <= align_cnt + AW'(1);
                    end
                end
                ST_RUN: begin
                    enc_valid <= 1'b1;
                    if (s_valid && s_ready) begin
                        enc_data <= s_data;
                        enc_k    <= 1'b0;
                    end else begin
                        enc_data <= COMMA;
                        enc_k    <= 1'b1;
                    end
                    // Idle commas count toward the skip cadence just like data.
                    if (sym_cnt == SYM_LAST) begin
                        sym_cnt <= '0;
                        state   <= ST_SKIP;
                    end else begin
                        sym_cnt <= sym_cnt + SW'(1);
                    end
                end
                ST_SKIP: begin
                    enc_data  <= SKIP_SYM;
                    enc_k     <= 1'b1;
                    enc_valid <= 1'b1;
                    if (skip_cnt == SKIP_LAST) begin
                        skip_cnt <= '0;
                        state    <= ST_RUN;
                    end else begin
                        skip_cnt <= skip_cnt + KW'(1);
                    end
                end
                default: begin
                    state     <= ST_OFF;
                    enc_valid <= 1'b0;
                    link_up   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serdes_tx_link_sequencer.sv
// Directed bench for serdes_tx_link_sequencer: small-parameter instance for cadence scenarios,
// default-parameter instance for the 1024-symbol skip interval.
module tb_serdes_tx_link_sequencer;

    logic       clk;
    logic       rst_n;
    logic       link_en;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] enc_data;
    logic       enc_k;
    logic       enc_valid;
    logic       link_up;

    logic       link_en_d;
    logic [7:0] s_data_d;
    logic       s_valid_d;
    logic       s_ready_d;
    logic [7:0] enc_data_d;
    logic       enc_k_d;
    logic       enc_valid_d;
    logic       link_up_d;

    int checks;
    int passed;

    serdes_tx_link_sequencer #(
        .ALIGN_CNT    (4),
        .SKIP_INTERVAL(8),
        .SKIP_LEN     (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .link_en  (link_en),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .enc_data (enc_data),
        .enc_k    (enc_k),
        .enc_valid(enc_valid),
        .link_up  (link_up)
    );

    serdes_tx_link_sequencer dut_def (
        .clk      (clk),
        .rst_n    (rst_n),
        .link_en  (link_en_d),
        .s_data   (s_data_d),
        .s_valid  (s_valid_d),
        .s_ready  (s_ready_d),
        .enc_data (enc_data_d),
        .enc_k    (enc_k_d),
        .enc_valid(enc_valid_d),
        .link_up  (link_up_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time expired, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves both DUTs in OFF with link_en low, 1 time unit after a clock edge.
    task automatic apply_reset();
        rst_n     = 1'b0;
        link_en   = 1'b0;
        s_valid   = 1'b0;
        s_data    = 8'h00;
        link_en_d = 1'b0;
        s_valid_d = 1'b0;
        s_data_d  = 8'h00;
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Raises link_en from OFF; expects one empty cycle, then 4 commas, link_up/s_ready on the last.
    task automatic do_align(input string tag);
        link_en = 1'b1;
        step();
        checks++;
        if ({enc_valid, enc_k, enc_data, link_up, s_ready} !== 12'h000)
            $display("[TB] FAIL %s_align_gap: got %h, expected %h", tag,
                     {enc_valid, enc_k, enc_data, link_up, s_ready}, 12'h000);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({enc_valid, enc_k, enc_data, link_up, s_ready} !== {2'b11, 8'hBC, i == 3, i == 3})
                $display("[TB] FAIL %s_align%0d: got %h, expected %h", tag, i,
                         {enc_valid, enc_k, enc_data, link_up, s_ready}, {2'b11, 8'hBC, i == 3, i == 3});
            else passed++;
        end
    endtask

    // From the first RUN issue cycle: nsets x (8 RUN symbols + 2 skips); pat[r] selects data for RUN symbol r.
    task automatic run_cadence(input string tag, input logic [31:0] pat, input int nsets, input logic [7:0] base);
        int r;
        logic [10:0] exp;
        r = 0;
        for (int s = 0; s < nsets; s++) begin
            for (int j = 0; j < 8; j++) begin
                s_valid = pat[r];
                s_data  = base + 8'(r);
                checks++;
                if (s_ready !== 1'b1)
                    $display("[TB] FAIL %s_ready_run%0d: got %b, expected 1", tag, r, s_ready);
                else passed++;
                step();
                exp = pat[r] ? {2'b10, base + 8'(r)} : {2'b11, 8'hBC};
                checks++;
                if ({enc_valid, enc_k, enc_data} !== exp || link_up !== 1'b1)
                    $display("[TB] FAIL %s_run%0d: got %h/up=%b, expected %h/up=1", tag, r,
                             {enc_valid, enc_k, enc_data}, link_up, exp);
                else passed++;
                r++;
            end
            s_valid = 1'b0;
            for (int j = 0; j < 2; j++) begin
                checks++;
                if (s_ready !== 1'b0)
                    $display("[TB] FAIL %s_ready_skip%0d: got %b, expected 0", tag, s, s_ready);
                else passed++;
                step();
                checks++;
                if ({enc_valid, enc_k, enc_data, link_up} !== {2'b11, 8'h1C, 1'b1})
                    $display("[TB] FAIL %s_skip%0d_%0d: got %h, expected %h", tag, s, j,
                             {enc_valid, enc_k, enc_data, link_up}, {2'b11, 8'h1C, 1'b1});
                else passed++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        link_en = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hFF;
        #3;
        checks++;
        if ({enc_valid, enc_k, enc_data, link_up, s_ready} !== 12'h000)
            $display("[TB] FAIL reset_outputs: got %h, expected %h",
                     {enc_valid, enc_k, enc_data, link_up, s_ready}, 12'h000);
        else passed++;
        step();
        checks++;
        if ({enc_valid_d, enc_k_d, enc_data_d, link_up_d, s_ready_d} !== 12'h000)
            $display("[TB] FAIL reset_outputs_def: got %h, expected %h",
                     {enc_valid_d, enc_k_d, enc_data_d, link_up_d, s_ready_d}, 12'h000);
        else passed++;
        apply_reset();
        checks++;
        if ({enc_valid, link_up, s_ready} !== 3'b000)
            $display("[TB] FAIL off_idle: got %b, expected 000", {enc_valid, link_up, s_ready});
        else passed++;
    endtask

    task automatic test_idle_cadence();
        apply_reset();
        do_align("idle");
        run_cadence("idle", 32'h0, 2, 8'h00);
    endtask

    task automatic test_stream();
        logic acc;
        int sent;
        int n;
        apply_reset();
        s_valid = 1'b1;
        s_data  = 8'h00;
        sent    = 0;
        n       = 0;
        do_align("stream");
        for (int s = 0; s < 32; s++) begin
            for (int j = 0; j < 8; j++) begin
                checks++;
                if (s_ready !== 1'b1)
                    $display("[TB] FAIL stream_ready_run%0d: got %b, expected 1", n, s_ready);
                else passed++;
                acc = s_ready & s_valid;
                step();
                if (acc) begin
                    sent++;
                    s_data = s_data + 8'd1;
                    if (sent == 256) s_valid = 1'b0;
                end
                checks++;
                if ({enc_valid, enc_k, enc_data} !== {2'b10, 8'(n)})
                    $display("[TB] FAIL stream_byte%0d: got %h, expected %h", n,
                             {enc_valid, enc_k, enc_data}, {2'b10, 8'(n)});
                else passed++;
                n++;
            end
            for (int j = 0; j < 2; j++) begin
                checks++;
                if (s_ready !== 1'b0)
                    $display("[TB] FAIL stream_ready_skip%0d: got %b, expected 0", s, s_ready);
                else passed++;
                step();
                checks++;
                if ({enc_valid, enc_k, enc_data} !== {2'b11, 8'h1C})
                    $display("[TB] FAIL stream_skip%0d: got %h, expected %h", s,
                             {enc_valid, enc_k, enc_data}, {2'b11, 8'h1C});
                else passed++;
            end
        end
        checks++;
        if (sent != 256)
            $display("[TB] FAIL stream_accepted: got %0d, expected 256", sent);
        else passed++;
        s_valid = 1'b0;
    endtask

    task automatic test_gaps();
        apply_reset();
        do_align("gaps");
        run_cadence("gaps", 32'h0047_2C4D, 3, 8'h40);
    endtask

    task automatic test_link_drop();
        apply_reset();
        do_align("drop");
        run_cadence("drop_pre", 32'h0, 1, 8'h00);
        for (int j = 0; j < 9; j++) step();
        checks++;
        if ({enc_valid, enc_k, enc_data} !== {2'b11, 8'h1C})
            $display("[TB] FAIL drop_first_skip: got %h, expected %h",
                     {enc_valid, enc_k, enc_data}, {2'b11, 8'h1C});
        else passed++;
        link_en = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            checks++;
            if ({enc_valid, enc_k, enc_data, link_up, s_ready} !== 12'h000)
                $display("[TB] FAIL drop_down%0d: got %h, expected %h", j,
                         {enc_valid, enc_k, enc_data, link_up, s_ready}, 12'h000);
            else passed++;
        end
        do_align("drop_re");
        run_cadence("drop_re", 32'h0, 1, 8'h00);
        for (int j = 0; j < 3; j++) step();
        s_valid = 1'b1;
        s_data  = 8'hA5;
        link_en = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b0)
            $display("[TB] FAIL drop_ready_comb: got %b, expected 0", s_ready);
        else passed++;
        step();
        checks++;
        if ({enc_valid, enc_k, enc_data, link_up} !== 11'h000)
            $display("[TB] FAIL drop_no_accept: got %h, expected %h",
                     {enc_valid, enc_k, enc_data, link_up}, 11'h000);
        else passed++;
        do_align("drop_mid");
        run_cadence("drop_mid", 32'h1, 1, 8'hA5);
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        do_align("rst");
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = 8'h10 + 8'(i);
            step();
            checks++;
            if ({enc_valid, enc_k, enc_data} !== {2'b10, 8'h10 + 8'(i)})
                $display("[TB] FAIL rst_pre%0d: got %h, expected %h", i,
                         {enc_valid, enc_k, enc_data}, {2'b10, 8'h10 + 8'(i)});
            else passed++;
        end
        s_data = 8'h77;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({enc_valid, enc_k, enc_data, link_up, s_ready} !== 12'h000)
            $display("[TB] FAIL rst_async: got %h, expected %h",
                     {enc_valid, enc_k, enc_data, link_up, s_ready}, 12'h000);
        else passed++;
        step();
        checks++;
        if ({enc_valid, enc_k, enc_data, link_up, s_ready} !== 12'h000)
            $display("[TB] FAIL rst_held: got %h, expected %h",
                     {enc_valid, enc_k, enc_data, link_up, s_ready}, 12'h000);
        else passed++;
        rst_n = 1'b1;
        do_align("rst_re");
        step();
        checks++;
        if ({enc_valid, enc_k, enc_data} !== {2'b10, 8'h77})
            $display("[TB] FAIL rst_pending_byte: got %h, expected %h",
                     {enc_valid, enc_k, enc_data}, {2'b10, 8'h77});
        else passed++;
        s_valid = 1'b0;
    endtask

    task automatic test_default_interval();
        int n;
        int bad;
        apply_reset();
        s_valid_d = 1'b1;
        s_data_d  = 8'h5A;
        link_en_d = 1'b1;
        step();
        checks++;
        if ({enc_valid_d, link_up_d} !== 2'b00)
            $display("[TB] FAIL def_gap: got %b, expected 00", {enc_valid_d, link_up_d});
        else passed++;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if ({enc_valid_d, enc_k_d, enc_data_d} !== {2'b11, 8'hBC}) bad++;
        end
        checks++;
        if (bad != 0 || link_up_d !== 1'b1)
            $display("[TB] FAIL def_align: got %0d bad commas up=%b, expected 0 bad up=1", bad, link_up_d);
        else passed++;
        n = 0;
        for (int i = 0; i < 1100; i++) begin
            step();
            if ({enc_valid_d, enc_k_d, enc_data_d} === {2'b10, 8'h5A}) n++;
            else break;
        end
        checks++;
        if (n != 1024)
            $display("[TB] FAIL def_interval: got %0d data symbols, expected 1024", n);
        else passed++;
        checks++;
        if ({enc_valid_d, enc_k_d, enc_data_d} !== {2'b11, 8'h1C})
            $display("[TB] FAIL def_skip0: got %h, expected %h",
                     {enc_valid_d, enc_k_d, enc_data_d}, {2'b11, 8'h1C});
        else passed++;
        step();
        checks++;
        if ({enc_valid_d, enc_k_d, enc_data_d} !== {2'b11, 8'h1C})
            $display("[TB] FAIL def_skip1: got %h, expected %h",
                     {enc_valid_d, enc_k_d, enc_data_d}, {2'b11, 8'h1C});
        else passed++;
        step();
        checks++;
        if ({enc_valid_d, enc_k_d, enc_data_d} !== {2'b10, 8'h5A})
            $display("[TB] FAIL def_resume: got %h, expected %h",
                     {enc_valid_d, enc_k_d, enc_data_d}, {2'b10, 8'h5A});
        else passed++;
        link_en_d = 1'b0;
        s_valid_d = 1'b0;
    endtask

    initial begin
        checks    = 0;
        passed    = 0;
        rst_n     = 1'b0;
        link_en   = 1'b0;
        s_valid   = 1'b0;
        s_data    = 8'h00;
        link_en_d = 1'b0;
        s_valid_d = 1'b0;
        s_data_d  = 8'h00;
        test_reset();
        test_idle_cadence();
        test_stream();
        test_gaps();
        test_link_drop();
        test_reset_midstream();
        test_default_interval();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
